// File: rtl/serial_tx_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_tx_fifo_pkg
//  Description : Shared FSM encodings and helpers for the serial link blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_tx_fifo_pkg;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_GAP   = 2'd2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_tx_fifo_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : serial_fifo
//  Description : Synchronous word FIFO with async clear and occupancy count.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_fifo
    import serial_tx_fifo_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           sclk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic [DATA_W-1:0]              wr_data,
    output logic [DATA_W-1:0]              rd_data,
    output logic                           full,
    output logic                           empty,
    output logic [clog2(FIFO_DEPTH):0]     level
);

    localparam int              c_AW   = clog2(FIFO_DEPTH);
    localparam logic [c_AW:0]   c_FULL = FIFO_DEPTH[c_AW:0];

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_level;
    logic              w_push;
    logic              w_pop;

    assign w_push  = push && !full;
    assign w_pop   = pop && !empty;
    assign full    = (r_level == c_FULL);
    assign empty   = (r_level == '0);
    assign level   = r_level;
    assign rd_data = r_mem[r_rd_ptr];

    // Depth is a power of two, so pointers wrap naturally.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge sclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : serial_tx_fifo
//  Description : Buffered serial word sender with framing, bit order and gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_tx_fifo
    import serial_tx_fifo_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST  = 1,
    parameter int GAP_CYCLES = 1
) (
    input  logic                           sclk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_W-1:0]              in_data,
    output logic                           data_enable,
    output logic                           sdo,
    output logic                           busy,
    output logic [clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int                 c_CNT_W    = clog2(DATA_W);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(DATA_W - 1);
    localparam logic [3:0]         c_GAP_LOAD = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit                 c_NO_GAP   = (GAP_CYCLES == 0);

    logic [1:0]         r_state;
    logic [DATA_W-1:0]  r_shreg;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [3:0]         r_gap_cnt;
    logic               r_data_enable;
    logic               r_sdo;

    logic [DATA_W-1:0]  w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_word_done;
    logic               w_gap_done;
    logic               w_first_bit;
    logic               w_next_bit;
    logic [DATA_W-1:0]  w_load_rem;
    logic [DATA_W-1:0]  w_shifted;

    serial_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sclk    (sclk),
        .rst_n   (rst_n),
        .push    (in_valid),
        .pop     (w_pop),
        .wr_data (in_data),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .level   (fifo_level)
    );

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_first_bit = w_head[DATA_W-1];
            assign w_load_rem  = {w_head[DATA_W-2:0], 1'b0};
            assign w_next_bit  = r_shreg[DATA_W-1];
            assign w_shifted   = {r_shreg[DATA_W-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_first_bit = w_head[0];
            assign w_load_rem  = {1'b0, w_head[DATA_W-1:1]};
            assign w_next_bit  = r_shreg[0];
            assign w_shifted   = {1'b0, r_shreg[DATA_W-1:1]};
        end
    endgenerate

    assign w_word_done = (r_state == c_ST_SHIFT) && (r_bit_cnt == '0);
    assign w_gap_done  = (r_state == c_ST_GAP) && (r_gap_cnt == '0);

    // The final gap cycle loads the next word directly so the low time between
    // back-to-back words is exactly GAP_CYCLES.
    assign w_pop = !w_empty && ((r_state == c_ST_IDLE) || w_gap_done ||
                                (w_word_done && c_NO_GAP));

    assign in_ready    = !w_full;
    assign data_enable = r_data_enable;
    assign sdo         = r_sdo;
    assign busy        = (r_state != c_ST_IDLE) || !w_empty;

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_ST_IDLE;
            r_shreg       <= '0;
            r_bit_cnt     <= '0;
            r_gap_cnt     <= '0;
            r_data_enable <= 1'b0;
            r_sdo         <= 1'b0;
        end else if (w_pop) begin
            r_state       <= c_ST_SHIFT;
            r_shreg       <= w_load_rem;
            r_bit_cnt     <= c_LAST_BIT;
            r_data_enable <= 1'b1;
            r_sdo         <= w_first_bit;
        end else begin
            case (r_state)
                c_ST_SHIFT: begin
                    if (r_bit_cnt != '0) begin
                        r_shreg   <= w_shifted;
                        r_sdo     <= w_next_bit;
                        r_bit_cnt <= r_bit_cnt - 1'b1;
                    end else begin
                        r_data_enable <= 1'b0;
                        r_sdo         <= 1'b0;
                        r_gap_cnt     <= c_GAP_LOAD;
                        r_state       <= c_NO_GAP ? c_ST_IDLE : c_ST_GAP;
                    end
                end
                c_ST_GAP: begin
                    if (r_gap_cnt != '0) begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state       <= c_ST_IDLE;
                    r_data_enable <= 1'b0;
                    r_sdo         <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_tx_fifo
//  Description : Scoreboard bench for serial_tx_fifo in three configurations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_tx_fifo;

    logic sclk = 1'b0;
    logic rst_n;

    // a: defaults (32b, MSB first, gap 1); b: 8b LSB first gap 2; c: 8b MSB first gap 0
    logic        valid_a = 1'b0, ready_a, de_a, sdo_a, busy_a;
    logic [31:0] data_a  = '0;
    logic [2:0]  level_a;
    logic        valid_b = 1'b0, ready_b, de_b, sdo_b, busy_b;
    logic [7:0]  data_b  = '0;
    logic [2:0]  level_b;
    logic        valid_c = 1'b0, ready_c, de_c, sdo_c, busy_c;
    logic [7:0]  data_c  = '0;
    logic [2:0]  level_c;

    int total = 0;
    int bad   = 0;

    bit q_bits_a[$];
    bit q_bits_b[$];
    bit q_bits_c[$];
    int q_run_a[$];
    int q_run_b[$];
    int q_run_c[$];

    int acc_a = 0, acc_cnt_a = 0, lvl_a = 0, run_a = 0, run_b = 0, run_c = 0;
    int low_b = 0;
    bit prev_a = 0, prev_b = 0, prev_c = 0, seen_b = 0;

    serial_tx_fifo u_dut_a (
        .sclk(sclk), .rst_n(rst_n), .in_valid(valid_a), .in_ready(ready_a),
        .in_data(data_a), .data_enable(de_a), .sdo(sdo_a), .busy(busy_a),
        .fifo_level(level_a)
    );

    serial_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .MSB_FIRST(0), .GAP_CYCLES(2)) u_dut_b (
        .sclk(sclk), .rst_n(rst_n), .in_valid(valid_b), .in_ready(ready_b),
        .in_data(data_b), .data_enable(de_b), .sdo(sdo_b), .busy(busy_b),
        .fifo_level(level_b)
    );

    serial_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .MSB_FIRST(1), .GAP_CYCLES(0)) u_dut_c (
        .sclk(sclk), .rst_n(rst_n), .in_valid(valid_c), .in_ready(ready_c),
        .in_data(data_c), .data_enable(de_c), .sdo(sdo_c), .busy(busy_c),
        .fifo_level(level_c)
    );

    always #5 sclk = ~sclk;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(negedge sclk);
        #1;
    endtask

    // Accepted words become expected serial bits in transmit order.
    always @(posedge sclk) begin
        acc_a = (rst_n && valid_a && ready_a) ? 1 : 0;
        if (acc_a == 1) begin
            acc_cnt_a++;
            for (int b = 31; b >= 0; b--) q_bits_a.push_back(data_a[b]);
            q_run_a.push_back(32);
        end
        if (rst_n && valid_b && ready_b) begin
            for (int b = 0; b < 8; b++) q_bits_b.push_back(data_b[b]);
            q_run_b.push_back(8);
        end
        if (rst_n && valid_c && ready_c) begin
            for (int b = 7; b >= 0; b--) q_bits_c.push_back(data_c[b]);
        end
    end

    always @(negedge sclk) begin
        if (!rst_n) begin
            q_bits_a.delete(); q_run_a.delete(); q_bits_b.delete(); q_run_b.delete();
            q_bits_c.delete(); q_run_c.delete();
            prev_a = 0; run_a = 0; lvl_a = 0;
        end else begin
            lvl_a = lvl_a + acc_a - ((de_a && !prev_a) ? 1 : 0);
            check("a_level_model", level_a, lvl_a);
            if (de_a) begin
                run_a++;
                if (q_bits_a.size() == 0) check("a_unexpected_bit", 1, 0);
                else check("a_sdo", sdo_a, q_bits_a.pop_front());
            end else begin
                check("a_sdo_idle", sdo_a, 0);
                if (prev_a) begin
                    if (q_run_a.size() == 0) check("a_unexpected_frame", 1, 0);
                    else check("a_frame_len", run_a, q_run_a.pop_front());
                    run_a = 0;
                end
            end
            prev_a = de_a;
        end
    end

    always @(negedge sclk) begin
        if (!rst_n) begin
            prev_b = 0; run_b = 0; low_b = 0; seen_b = 0;
        end else begin
            if (de_b) begin
                if (!prev_b && seen_b) check("b_gap_len", low_b, 2);
                run_b++;
                if (q_bits_b.size() == 0) check("b_unexpected_bit", 1, 0);
                else check("b_sdo", sdo_b, q_bits_b.pop_front());
            end else begin
                check("b_sdo_idle", sdo_b, 0);
                if (prev_b) begin
                    if (q_run_b.size() == 0) check("b_unexpected_frame", 1, 0);
                    else check("b_frame_len", run_b, q_run_b.pop_front());
                    run_b = 0; low_b = 0; seen_b = 1;
                end
                low_b++;
            end
            prev_b = de_b;
        end
    end

    always @(negedge sclk) begin
        if (!rst_n) begin
            prev_c = 0; run_c = 0;
        end else begin
            if (de_c) begin
                run_c++;
                if (q_bits_c.size() == 0) check("c_unexpected_bit", 1, 0);
                else check("c_sdo", sdo_c, q_bits_c.pop_front());
            end else begin
                check("c_sdo_idle", sdo_c, 0);
                if (prev_c) begin
                    if (q_run_c.size() == 0) check("c_unexpected_frame", 1, 0);
                    else check("c_frame_len", run_c, q_run_c.pop_front());
                    run_c = 0;
                end
            end
            prev_c = de_c;
        end
    end

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((busy_a || busy_b || busy_c) && n < limit) begin
            tick();
            n++;
        end
        check("idle_timeout", busy_a | busy_b | busy_c, 0);
        tick();
        tick();
    endtask

    initial begin
        int n;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        tick();
        tick();
        check("rst_de", de_a, 0);
        check("rst_sdo", sdo_a, 0);
        check("rst_ready", ready_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_level", level_a, 0);
        rst_n = 1'b1;
        tick();

        // single word, default configuration
        valid_a = 1'b1; data_a = 32'hA500_0001;
        tick();
        valid_a = 1'b0;
        check("t1_busy_queued", busy_a, 1);
        check("t1_de_before", de_a, 0);
        check("t1_level", level_a, 1);
        tick();
        check("t1_de_first", de_a, 1);
        check("t1_first_bit", sdo_a, 1);
        n = 0;
        do begin tick(); n++; end while (de_a && n < 40);
        check("t1_de_fall", de_a, 0);
        check("t1_busy_in_gap", busy_a, 1);
        tick();
        check("t1_busy_after_gap", busy_a, 0);
        check("t1_level_end", level_a, 0);
        wait_idle(20);

        // LSB first with a two-cycle gap
        valid_b = 1'b1; data_b = 8'h81;
        tick();
        data_b = 8'h03;
        tick();
        valid_b = 1'b0;
        wait_idle(60);
        check("t2_gap_seen", seen_b, 1);

        // continuous stream, no gap
        q_run_c.push_back(24);
        valid_c = 1'b1; data_c = 8'hB4;
        tick();
        data_c = 8'h5A;
        tick();
        check("t3_level_push_pop", level_c, 1);
        data_c = 8'hE1;
        tick();
        check("t3_level_two", level_c, 2);
        valid_c = 1'b0;
        wait_idle(60);

        // fill while shifting, then refill at the end-of-word pop
        acc_cnt_a = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (i == 5) begin
                check("t4_level_full", level_a, 4);
                check("t4_ready_full", ready_a, 0);
            end
            if (i == 35) begin
                check("t6_level_after_pop", level_a, 3);
                check("t6_ready_after_pop", ready_a, 1);
            end
            if (i == 36) check("t6_level_refill", level_a, 4);
            valid_a = 1'b1;
            data_a  = 32'hC0DE_0000 + i;
        end
        tick();
        valid_a = 1'b0;
        check("t4_accepted", acc_cnt_a, 6);
        wait_idle(400);

        // reset in the middle of a word
        valid_a = 1'b1; data_a = 32'h1234_5678;
        tick();
        data_a = 32'h0F0F_0F0F;
        tick();
        valid_a = 1'b0;
        n = 0;
        while (n < 10) begin
            if (de_a) n++;
            if (n < 10) tick();
        end
        check("t5_level_pre", level_a, 1);
        rst_n = 1'b0;
        #1;
        check("t5_de", de_a, 0);
        check("t5_sdo", sdo_a, 0);
        check("t5_level", level_a, 0);
        check("t5_ready", ready_a, 1);
        check("t5_busy", busy_a, 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t5_idle_de", de_a, 0);
            check("t5_idle_busy", busy_a, 0);
        end
        valid_a = 1'b1; data_a = 32'h8000_0001;
        tick();
        valid_a = 1'b0;
        wait_idle(60);

        check("end_bits_a", q_bits_a.size(), 0);
        check("end_bits_b", q_bits_b.size(), 0);
        check("end_bits_c", q_bits_c.size(), 0);
        check("end_runs_a", q_run_a.size(), 0);
        check("end_runs_b", q_run_b.size(), 0);
        check("end_runs_c", q_run_c.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
